// File: rtl/counter_run_ctrl.sv
// Sequencing controller for a WIDTH-bit up-counter: launch, pause/resume, abort,
// terminal-count detect with a one-cycle done pulse, one-shot or auto-reload.
module counter_run_ctrl #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             stop,
    input  logic             abort,
    input  logic             auto_reload,
    input  logic [WIDTH-1:0] term_val,
    output logic [WIDTH-1:0] count,
    output logic             busy,
    output logic             paused,
    output logic             done,
    output logic [1:0]       state
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t           st;
    logic [WIDTH-1:0] cnt;
    logic [WIDTH-1:0] term_reg;
    logic             reload_reg;
    logic             done_r;

    always_ff @(posedge clk) begin
        if (rst) begin
            st         <= IDLE;
            cnt        <= '0;
            term_reg   <= '0;
            reload_reg <= 1'b0;
            done_r     <= 1'b0;
        end else begin
            done_r <= 1'b0;
            if (abort) begin
                st  <= IDLE;
                cnt <= '0;
            end else begin
                unique case (st)
                    IDLE, DONE: begin
                        if (start) begin
                            term_reg   <= term_val;
                            reload_reg <= auto_reload;
                            cnt        <= '0;
                            st         <= RUN;
                        end
                    end
                    RUN: begin
                        // Terminal event outranks stop; start is ignored mid-run.
                        if (cnt == term_reg) begin
                            done_r <= 1'b1;
                            if (reload_reg) begin
                                cnt <= '0;
                            end else begin
                                st <= DONE;
                            end
                        end else if (stop) begin
                            st <= PAUSE;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                    PAUSE: begin
                        if (start && !stop) begin
                            st <= RUN;
                        end
                    end
                    default: st <= IDLE;
                endcase
            end
        end
    end

    assign count  = cnt;
    assign done   = done_r;
    assign state  = st;
    assign busy   = (st == RUN) || (st == PAUSE);
    assign paused = (st == PAUSE);

endmodule

// File: tb/tb_counter_run_ctrl.sv
// Directed, table-driven bench for counter_run_ctrl plus hand-written
// sequences for auto-reload period measurement and mid-run reset.
module tb_counter_run_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       start = 1'b0;
    logic       stop = 1'b0;
    logic       abort = 1'b0;
    logic       auto_reload = 1'b0;
    logic [3:0] term_val = 4'd0;
    logic [3:0] count;
    logic       busy;
    logic       paused;
    logic       done;
    logic [1:0] state;

    int n_tests = 0;
    int n_fail  = 0;

    counter_run_ctrl #(.WIDTH(4)) dut (
        .clk(clk),
        .rst(rst),
        .start(start),
        .stop(stop),
        .abort(abort),
        .auto_reload(auto_reload),
        .term_val(term_val),
        .count(count),
        .busy(busy),
        .paused(paused),
        .done(done),
        .state(state)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       rst;
        logic       start;
        logic       stop;
        logic       abort;
        logic       ar;
        logic [3:0] tv;
        logic [3:0] ecount;
        logic [1:0] est;
        logic       edone;
    } vec_t;

    vec_t tbl[$];

    localparam logic [1:0] S_IDLE = 2'd0, S_RUN = 2'd1, S_PAUSE = 2'd2, S_DONE = 2'd3;

    task automatic add(input logic r, input logic s, input logic sp, input logic ab,
                       input logic ar, input logic [3:0] tv, input logic [3:0] ec,
                       input logic [1:0] es, input logic ed);
        vec_t x;
        x.rst = r; x.start = s; x.stop = sp; x.abort = ab; x.ar = ar; x.tv = tv;
        x.ecount = ec; x.est = es; x.edone = ed;
        tbl.push_back(x);
    endtask

    task automatic check(input string name, input logic [3:0] ec, input logic [1:0] es,
                         input logic ed);
        logic [8:0] got, exp;
        got = {count, state, done, busy, paused};
        exp = {ec, es, ed, (es == S_RUN) || (es == S_PAUSE), es == S_PAUSE};
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got count=%0d state=%0d done=%b busy=%b paused=%b, expected count=%0d state=%0d done=%b busy=%b paused=%b",
                     name, got[8:5], got[4:3], got[2], got[1], got[0],
                     exp[8:5], exp[4:3], exp[2], exp[1], exp[0]);
        end
    endtask

    task automatic drive(input logic r, input logic s, input logic sp, input logic ab,
                         input logic ar, input logic [3:0] tv);
        rst = r; start = s; stop = sp; abort = ab; auto_reload = ar; term_val = tv;
        @(posedge clk);
        #1;
    endtask

    initial begin
        int first_done;
        int second_done;
        int npulse;
        logic busy_ok;

        // Reset with start held, then launch one-shot T=5.
        add(1, 1, 0, 0, 0, 4'd0, 4'd0, S_IDLE, 0);
        add(1, 1, 0, 0, 0, 4'd0, 4'd0, S_IDLE, 0);
        add(0, 1, 0, 0, 0, 4'd5, 4'd0, S_RUN, 0);
        add(0, 0, 0, 0, 0, 4'd5, 4'd1, S_RUN, 0);
        add(0, 1, 0, 0, 0, 4'd5, 4'd2, S_RUN, 0);
        add(0, 0, 0, 0, 0, 4'd5, 4'd3, S_RUN, 0);
        add(0, 0, 0, 0, 0, 4'd5, 4'd4, S_RUN, 0);
        add(0, 0, 0, 0, 0, 4'd5, 4'd5, S_RUN, 0);
        add(0, 0, 0, 0, 0, 4'd5, 4'd5, S_DONE, 1);
        for (int i = 0; i < 10; i++) add(0, 0, 0, 0, 0, 4'd5, 4'd5, S_DONE, 0);
        add(0, 0, 0, 1, 0, 4'd5, 4'd0, S_IDLE, 0);
        add(0, 0, 1, 0, 0, 4'd5, 4'd0, S_IDLE, 0);

        // Auto-reload T=3; term_val/auto_reload changed mid-run must not matter.
        add(0, 1, 0, 0, 1, 4'd3, 4'd0, S_RUN, 0);
        add(0, 0, 0, 0, 1, 4'd3, 4'd1, S_RUN, 0);
        add(0, 0, 0, 0, 1, 4'd3, 4'd2, S_RUN, 0);
        add(0, 0, 0, 0, 1, 4'd3, 4'd3, S_RUN, 0);
        add(0, 0, 0, 0, 1, 4'd3, 4'd0, S_RUN, 1);
        add(0, 0, 0, 0, 0, 4'd2, 4'd1, S_RUN, 0);
        add(0, 0, 0, 0, 0, 4'd2, 4'd2, S_RUN, 0);
        add(0, 0, 0, 0, 0, 4'd2, 4'd3, S_RUN, 0);
        add(0, 0, 0, 0, 0, 4'd2, 4'd0, S_RUN, 1);
        add(0, 0, 0, 0, 0, 4'd2, 4'd1, S_RUN, 0);
        add(0, 0, 0, 1, 0, 4'd2, 4'd0, S_IDLE, 0);

        // Pause/resume, one-shot T=9; count frozen for 3 edges, done at edge 13.
        add(0, 1, 0, 0, 0, 4'd9, 4'd0, S_RUN, 0);
        for (int k = 1; k <= 4; k++) add(0, 0, 0, 0, 0, 4'd9, 4'(k), S_RUN, 0);
        add(0, 0, 1, 0, 0, 4'd9, 4'd4, S_PAUSE, 0);
        add(0, 1, 1, 0, 0, 4'd9, 4'd4, S_PAUSE, 0);
        add(0, 1, 0, 0, 1, 4'd1, 4'd4, S_RUN, 0);
        for (int k = 5; k <= 9; k++) add(0, 0, 0, 0, 0, 4'd9, 4'(k), S_RUN, 0);
        add(0, 0, 0, 0, 0, 4'd9, 4'd9, S_DONE, 1);
        add(0, 0, 0, 0, 0, 4'd9, 4'd9, S_DONE, 0);

        // Relaunch from DONE, abort at count==term: no done.
        add(0, 1, 0, 0, 0, 4'd2, 4'd0, S_RUN, 0);
        add(0, 0, 0, 0, 0, 4'd2, 4'd1, S_RUN, 0);
        add(0, 0, 0, 0, 0, 4'd2, 4'd2, S_RUN, 0);
        add(0, 0, 0, 1, 0, 4'd2, 4'd0, S_IDLE, 0);
        add(0, 0, 0, 0, 0, 4'd2, 4'd0, S_IDLE, 0);

        // Stop at count==term: terminal event wins.
        add(0, 1, 0, 0, 0, 4'd2, 4'd0, S_RUN, 0);
        add(0, 0, 0, 0, 0, 4'd2, 4'd1, S_RUN, 0);
        add(0, 0, 0, 0, 0, 4'd2, 4'd2, S_RUN, 0);
        add(0, 0, 1, 0, 0, 4'd2, 4'd2, S_DONE, 1);
        add(0, 0, 0, 0, 0, 4'd2, 4'd2, S_DONE, 0);

        // term_val=0 auto-reload: done every cycle.
        add(0, 1, 0, 0, 1, 4'd0, 4'd0, S_RUN, 0);
        for (int i = 0; i < 4; i++) add(0, 0, 0, 0, 1, 4'd0, 4'd0, S_RUN, 1);
        add(0, 0, 0, 1, 1, 4'd0, 4'd0, S_IDLE, 0);

        // term_val=15 auto-reload: wraps to 0 with one done per 16 cycles.
        add(0, 1, 0, 0, 1, 4'd15, 4'd0, S_RUN, 0);
        for (int k = 1; k <= 15; k++) add(0, 0, 0, 0, 1, 4'd15, 4'(k), S_RUN, 0);
        add(0, 0, 0, 0, 1, 4'd15, 4'd0, S_RUN, 1);
        for (int k = 1; k <= 15; k++) add(0, 0, 0, 0, 1, 4'd15, 4'(k), S_RUN, 0);
        add(0, 0, 0, 0, 1, 4'd15, 4'd0, S_RUN, 1);
        add(0, 0, 0, 1, 1, 4'd15, 4'd0, S_IDLE, 0);

        @(posedge clk);
        #1;
        foreach (tbl[i]) begin
            drive(tbl[i].rst, tbl[i].start, tbl[i].stop, tbl[i].abort, tbl[i].ar, tbl[i].tv);
            check($sformatf("vec%0d", i), tbl[i].ecount, tbl[i].est, tbl[i].edone);
        end

        // Auto-reload T=6: first done after edge 7, then every 7 cycles.
        drive(0, 1, 0, 0, 1, 4'd6);
        check("launch_t6", 4'd0, S_RUN, 0);
        first_done = -1; second_done = -1; npulse = 0; busy_ok = 1'b1;
        for (int e = 1; e <= 40 && npulse < 2; e++) begin
            drive(0, 0, 0, 0, 1, 4'd6);
            if (!busy) busy_ok = 1'b0;
            if (done) begin
                if (npulse == 0) first_done = e;
                else second_done = e;
                npulse++;
            end
        end
        n_tests++;
        if (first_done != 7) begin
            n_fail++;
            $display("FAIL first_done_edge: got %0d, expected 7", first_done);
        end
        n_tests++;
        if (second_done - first_done != 7) begin
            n_fail++;
            $display("FAIL done_period: got %0d (edges %0d,%0d), expected 7", second_done - first_done, first_done, second_done);
        end
        n_tests++;
        if (!busy_ok) begin
            n_fail++;
            $display("FAIL busy_during_reload: got busy drop, expected busy=1 throughout");
        end

        // Reset mid-run beats every other input.
        drive(0, 0, 0, 0, 1, 4'd6);
        drive(1, 1, 1, 1, 1, 4'd6);
        check("mid_run_reset", 4'd0, S_IDLE, 0);
        drive(0, 0, 0, 0, 0, 4'd6);
        check("idle_after_reset", 4'd0, S_IDLE, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/counter_run_ctrl.md
Name: counter_run_ctrl

Overview:
- Sequencing controller for a WIDTH-bit up-counter datapath.
- Owns the count register and a small FSM: start, pause/resume, abort, terminal-count detect, one-shot or auto-reload operation.
- Used wherever a block needs a programmable cycle timer with a one-cycle completion pulse.
- Single clock domain, no handshake beyond level/pulse controls.

Parameters:
- WIDTH, 4, width of count and term_val.

Ports:
- clk  input  1  system clock; all state changes on rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  launch (IDLE/DONE) or resume (PAUSE).
- stop  input  1  pause request while running.
- abort  input  1  return to IDLE, clear count.
- auto_reload  input  1  mode, sampled on launch: 1 = periodic, 0 = one-shot.
- term_val  input  WIDTH  terminal count, sampled on launch.
- count  output  WIDTH  current count value.
- busy  output  1  high in RUN or PAUSE.
- paused  output  1  high in PAUSE.
- done  output  1  one-cycle pulse on each terminal-count event.
- state  output  2  FSM state encoding, debug: IDLE=0, RUN=1, PAUSE=2, DONE=3.

Behaviour:
- Reset: when rst=1 at an edge, the following apply regardless of other inputs:
  - state=IDLE, count=0, busy=0, paused=0, done=0, term_reg=0, reload_reg=0.
- Input priority at each edge: rst > abort > terminal event > stop > start.
- abort, any non-IDLE state:
  - Next state IDLE, count=0, done=0.
  - No done is produced, even when count==term_reg that cycle.
- IDLE:
  - start=1 is a launch: term_reg<=term_val, reload_reg<=auto_reload, count<=0, next state RUN.
  - stop is ignored in IDLE.
- RUN, terminal event when count==term_reg:
  - done<=1 for exactly one cycle.
  - reload_reg=1: count<=0, stay in RUN.
  - reload_reg=0: count holds term_reg, next state DONE.
  - A stop asserted in the same cycle is ignored.
- RUN, otherwise:
  - stop=1: next state PAUSE, count held.
  - Else count<=count+1.
  - start is ignored while in RUN; there is no restart mid-run.
- PAUSE:
  - Count and done are frozen (done=0).
  - start=1 resumes to RUN with no re-sampling of term_val or auto_reload.
  - start and stop together: stop wins, remain in PAUSE.
- DONE:
  - count holds term_reg, done=0.
  - start=1 relaunches, identical to a launch from IDLE.
- Timing:
  - Launch at edge 0: count=k after edge k, for k=0..T where T=term_reg.
  - done is high in the cycle after edge T+1.
  - Period (auto-reload) is T+1 cycles.
  - Each paused cycle adds one cycle.
- Width rules:
  - All compares are unsigned WIDTH-bit; count never exceeds term_reg.
  - term_val=0 gives done every cycle in auto-reload mode, and after 1 cycle in one-shot mode.
  - term_val=2^WIDTH-1: count reaches all-ones, then reloads to 0; no overflow flag.
- Outputs:
  - All outputs are registered or decoded from registered state only.
  - No combinational path from any input to any output.
- Mid-operation changes: changing term_val or auto_reload while busy has no effect until the next launch.

Test Plan:
- Reset: rst=1 for 2 cycles with start=1 held.
  - Expect count=0, state=0, busy=0, done=0 throughout.
  - Then rst=0 with start=1: RUN, count=0 after the first non-reset edge.
- One-shot: term_val=5, auto_reload=0, start pulse.
  - Expect count 0,1,2,3,4,5 on successive edges.
  - Expect done=1 for one cycle, then state=DONE, count=5 held for 10+ cycles with done=0.
- Auto-reload: term_val=3, auto_reload=1.
  - Expect count sequence 0,1,2,3,0,1,2,3.
  - Expect done pulses exactly 4 cycles apart, busy=1 throughout.
- Pause/resume: term_val=9, stop pulse at count=4, hold 3 cycles, then start pulse.
  - Expect count=4 frozen and paused=1 during the pause.
  - Expect resume to 5..9 and done once; total launch-to-done of 10+3 cycles.
  - Also: start+stop together in PAUSE keeps PAUSE.
- Abort and terminal collisions:
  - abort at count==term (term_val=2): expect IDLE, count=0, no done.
  - stop at count==term (term_val=2, one-shot): expect done=1, state=DONE.
- Edge values, WIDTH=4:
  - term_val=0, auto_reload=1: expect done high every cycle, count=0.
  - term_val=15, auto_reload=1: expect count 0..15 then 0, done once per 16 cycles.
  - term_val changed to 2 mid-run: expect no effect until the next launch.
